// File: rtl/qam16_demapper_if.sv
// Stream bundle for the 16-QAM demapper: complex sample input and packed-byte output.
interface qam16_demapper_if;
   logic        s_valid;
   logic        s_ready;
   logic [15:0] s_data;
   logic        s_last;
   logic        m_valid;
   logic        m_ready;
   logic [7:0]  m_data;
   logic        m_last;
   logic        m_pad;

   modport slave  (input  s_valid, s_data, s_last, m_ready,
                   output s_ready, m_valid, m_data, m_last, m_pad);
   modport master (output s_valid, s_data, s_last, m_ready,
                   input  s_ready, m_valid, m_data, m_last, m_pad);
endinterface

// File: rtl/qam16_demapper.sv
// Hard-decision 16-QAM slicer + two-symbols-per-byte packer.
// Define QAM16_DEMAP_EVM_EN to build the squared-error accumulator on err_acc.
module qam16_demapper #(
   parameter int UNIT  = 1,
   parameter int ACC_W = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   qam16_demapper_if.slave  bus,
   input  logic             err_clr,
   output logic [ACC_W-1:0] err_acc
);

   typedef enum logic {EMPTY, HALF} pk_state_e;

   localparam logic signed [8:0] THR  = 9'(2 * UNIT);
   localparam logic signed [8:0] NTHR = -THR;

   // Level index: 0=-3, 1=-1, 2=+1, 3=+3
   function automatic logic [1:0] level(input logic [7:0] v);
      logic signed [8:0] x;
      x = {v[7], v};
      if (x >= THR)        level = 2'd3;
      else if (x >= 9'sd0) level = 2'd2;
      else if (x >= NTHR)  level = 2'd1;
      else                 level = 2'd0;
   endfunction

   logic       v1_q, v1_d;
   logic [3:0] sym1_q, sym1_d;
   logic       last1_q, last1_d;
   pk_state_e  st_q, st_d;
   logic [3:0] hi_q, hi_d;
   logic       ov_q, ov_d;
   logic [7:0] od_q, od_d;
   logic       ol_q, ol_d;
   logic       op_q, op_d;

   logic [1:0] re_l, im_l;
   logic [3:0] sym_in;
   logic       emit, out_free, adv1, ready, load;

   always_comb begin
      re_l     = level(bus.s_data[7:0]);
      im_l     = level(bus.s_data[15:8]);
      // Gray maps: real -3,-1,+1,+3 -> 00,01,11,10; imag -3,-1,+1,+3 -> 10,11,01,00
      sym_in   = {re_l[1], ^re_l, ~im_l[1], ^im_l};
      emit     = v1_q & ((st_q == HALF) | last1_q);
      out_free = !ov_q | bus.m_ready;
      adv1     = v1_q & (!emit | out_free);
      ready    = rst_n & (!v1_q | adv1);
      load     = bus.s_valid & ready;

      v1_d    = v1_q;
      sym1_d  = sym1_q;
      last1_d = last1_q;
      st_d    = st_q;
      hi_d    = hi_q;
      ov_d    = ov_q;
      od_d    = od_q;
      ol_d    = ol_q;
      op_d    = op_q;

      if (load) begin
         v1_d    = 1'b1;
         sym1_d  = sym_in;
         last1_d = bus.s_last;
      end else if (adv1) begin
         v1_d = 1'b0;
      end

      if (ov_q && bus.m_ready) ov_d = 1'b0;

      if (adv1) begin
         if (st_q == EMPTY && !last1_q) begin
            hi_d = sym1_q;
            st_d = HALF;
         end else begin
            ov_d = 1'b1;
            od_d = (st_q == HALF) ? {hi_q, sym1_q} : {sym1_q, 4'h0};
            ol_d = (st_q == HALF) ? last1_q : 1'b1;
            op_d = (st_q == EMPTY);
            st_d = EMPTY;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1_q    <= 1'b0;
         sym1_q  <= 4'h0;
         last1_q <= 1'b0;
         st_q    <= EMPTY;
         hi_q    <= 4'h0;
         ov_q    <= 1'b0;
         od_q    <= 8'h00;
         ol_q    <= 1'b0;
         op_q    <= 1'b0;
      end else begin
         v1_q    <= v1_d;
         sym1_q  <= sym1_d;
         last1_q <= last1_d;
         st_q    <= st_d;
         hi_q    <= hi_d;
         ov_q    <= ov_d;
         od_q    <= od_d;
         ol_q    <= ol_d;
         op_q    <= op_d;
      end
   end

   assign bus.s_ready = ready;
   assign bus.m_valid = ov_q;
   assign bus.m_data  = od_q;
   assign bus.m_last  = ol_q;
   assign bus.m_pad   = op_q;

`ifdef QAM16_DEMAP_EVM_EN
   localparam int EW = 17;
   localparam int SW = ((ACC_W > EW) ? ACC_W : EW) + 1;
   localparam logic [SW-1:0]      MAXS   = {{(SW-ACC_W){1'b0}}, {ACC_W{1'b1}}};
   localparam logic signed [9:0]  UNIT_S = 10'(UNIT);

   // |v - ideal| never exceeds 125 for any 8-bit input, so an 8x8 square suffices
   function automatic logic [15:0] sqerr(input logic [7:0] v, input logic [1:0] l);
      logic signed [9:0] lv, ideal, diff;
      logic [7:0]        mag;
      lv    = $signed({7'd0, l, 1'b0}) - 10'sd3;
      ideal = lv * UNIT_S;
      diff  = $signed({{2{v[7]}}, v}) - ideal;
      mag   = 8'(diff[9] ? -diff : diff);
      sqerr = 16'(mag) * 16'(mag);
   endfunction

   logic [EW-1:0]    e_in, e1_q, e1_d;
   logic             ld_q, ld_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [SW-1:0]    sel;

   always_comb begin
      e_in  = 17'(sqerr(bus.s_data[7:0], re_l)) + 17'(sqerr(bus.s_data[15:8], im_l));
      e1_d  = load ? e_in : e1_q;
      ld_d  = load;
      sel   = err_clr ? SW'(e1_q) : SW'(acc_q) + SW'(e1_q);
      acc_d = acc_q;
      if (ld_q)         acc_d = (sel > MAXS) ? '1 : sel[ACC_W-1:0];
      else if (err_clr) acc_d = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         e1_q  <= '0;
         ld_q  <= 1'b0;
         acc_q <= '0;
      end else begin
         e1_q  <= e1_d;
         ld_q  <= ld_d;
         acc_q <= acc_d;
      end
   end

   assign err_acc = acc_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign err_acc        = '0;
`endif

endmodule

// File: tb/tb_qam16_demapper.sv
// Directed bench for qam16_demapper: one UNIT=4 instance for slicing/packing, one UNIT=1/ACC_W=4 for latency and EVM.
`timescale 1ns/1ps
module tb_qam16_demapper;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   qam16_demapper_if if4();
   qam16_demapper_if if1();
   logic        err_clr4 = 1'b0;
   logic        err_clr1 = 1'b0;
   logic [23:0] err_acc4;
   logic [3:0]  err_acc1;

   qam16_demapper #(.UNIT(4), .ACC_W(24)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave),
                                             .err_clr(err_clr4), .err_acc(err_acc4));
   qam16_demapper #(.UNIT(1), .ACC_W(4))  u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave),
                                             .err_clr(err_clr1), .err_acc(err_acc1));

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int bp_from = 1 << 30;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if4.m_ready = !(cyc >= bp_from && cyc < bp_from + 10);

   // Output capture on u4: {last, pad, data}
   logic [9:0] cap[$];
   logic [9:0] exp_q[$];
   logic       saw_stall = 1'b0, unstable = 1'b0, held = 1'b0;
   logic [9:0] prev = '0;
   always @(posedge clk) begin
      if (rst_n && if4.m_valid && if4.m_ready) cap.push_back({if4.m_last, if4.m_pad, if4.m_data});
      if (rst_n && if4.s_valid && !if4.s_ready) saw_stall <= 1'b1;
      if (held && rst_n && {if4.m_last, if4.m_pad, if4.m_data} != prev) unstable <= 1'b1;
      held <= rst_n && if4.m_valid && !if4.m_ready;
      prev <= {if4.m_last, if4.m_pad, if4.m_data};
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic send4(input logic [15:0] d, input logic l);
      int n;
      n = 0;
      if4.s_valid = 1'b1; if4.s_data = d; if4.s_last = l;
      #1;
      while (if4.s_ready !== 1'b1 && n < 100) begin @(negedge clk); #1; n++; end
      if (n >= 100) chk("s_ready4_timeout", 32'd0, 32'd1);
      @(posedge clk); @(negedge clk);
   endtask

   task automatic send1(input logic [15:0] d, input logic l);
      int n;
      n = 0;
      if1.s_valid = 1'b1; if1.s_data = d; if1.s_last = l;
      #1;
      while (if1.s_ready !== 1'b1 && n < 100) begin @(negedge clk); #1; n++; end
      if (n >= 100) chk("s_ready1_timeout", 32'd0, 32'd1);
      @(posedge clk); @(negedge clk);
   endtask

   // Ideal constellation sample for a symbol at UNIT=4
   function automatic logic [15:0] pt(input logic [3:0] s);
      logic [7:0] re, im;
      case (s[3:2])
         2'b00: re = 8'hF4; 2'b01: re = 8'hFC; 2'b10: re = 8'h0C; default: re = 8'h04;
      endcase
      case (s[1:0])
         2'b00: im = 8'h0C; 2'b01: im = 8'h04; 2'b10: im = 8'hF4; default: im = 8'hFC;
      endcase
      return {im, re};
   endfunction

   logic       mhalf = 1'b0;
   logic [3:0] mhi = 4'h0;
   task automatic model_sym(input logic [3:0] s, input logic l);
      if (!mhalf) begin
         if (l) exp_q.push_back({2'b11, s, 4'h0});
         else begin mhi = s; mhalf = 1'b1; end
      end else begin
         exp_q.push_back({l, 1'b0, mhi, s});
         mhalf = 1'b0;
      end
   endtask

   task automatic cmp_bytes(input string tag);
      chk({tag, "_count"}, cap.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
         chk($sformatf("%s_byte%0d", tag, i), {22'd0, cap[i]}, {22'd0, exp_q[i]});
      cap.delete();
      exp_q.delete();
   endtask

   initial begin
      if4.s_valid = 1'b0; if4.s_data = '0; if4.s_last = 1'b0;
      if1.s_valid = 1'b0; if1.s_data = '0; if1.s_last = 1'b0; if1.m_ready = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_s_ready4", if4.s_ready, 0);
      chk("rst_s_ready1", if1.s_ready, 0);
      chk("rst_m_valid",  if4.m_valid, 0);
      chk("rst_m_data",   if4.m_data, 0);
      chk("rst_m_last",   if4.m_last, 0);
      chk("rst_m_pad",    if4.m_pad, 0);
      chk("rst_err_acc4", err_acc4, 0);
      chk("rst_err_acc1", err_acc1, 0);
      rst_n = 1'b1;
      @(negedge clk); #1;
      chk("post_rst_s_ready", if4.s_ready, 1);

      // Basic pair at UNIT=1, latency check
      send1(16'h03FD, 1'b0);
      send1(16'hFF01, 1'b1);
      if1.s_valid = 1'b0;
      chk("lat_not_yet", if1.m_valid, 0);
      @(negedge clk);
      chk("lat_m_valid", if1.m_valid, 1);
      chk("pair_data",   if1.m_data, 8'h0F);
      chk("pair_last",   if1.m_last, 1);
      chk("pair_pad",    if1.m_pad, 0);
      @(negedge clk);
      chk("pair_drained", if1.m_valid, 0);
      chk("pair_err_acc", err_acc1, 0);

      // Threshold edges at UNIT=4: re = 8,7,0,-1,-8,-9 -> syms 9,D,D,5,5,1
      send4(16'h0008, 1'b0); send4(16'h0007, 1'b0); send4(16'h0000, 1'b0);
      send4(16'h00FF, 1'b0); send4(16'h00F8, 1'b0); send4(16'h00F7, 1'b1);
      if4.s_valid = 1'b0;
      exp_q.push_back({2'b00, 8'h9D});
      exp_q.push_back({2'b00, 8'hD5});
      exp_q.push_back({2'b10, 8'h51});
      repeat (4) @(negedge clk);
      cmp_bytes("thresh");

      // Sweep of all 16 ideal points
      for (int s = 0; s < 16; s++) send4(pt(4'(s)), s == 15);
      if4.s_valid = 1'b0;
      for (int b = 0; b < 8; b++) exp_q.push_back({(b == 7), 1'b0, 4'(2*b), 4'(2*b+1)});
      repeat (4) @(negedge clk);
      cmp_bytes("sweep");

      // Odd frame: syms 5,6,9
      send4(16'h04FC, 1'b0); send4(16'hF4FC, 1'b0); send4(16'h040C, 1'b1);
      if4.s_valid = 1'b0;
      exp_q.push_back({2'b00, 8'h56});
      exp_q.push_back({2'b11, 8'h90});
      repeat (4) @(negedge clk);
      cmp_bytes("odd");

      // Backpressure: m_ready low for 10 cycles mid-stream
      bp_from = cyc + 4;
      for (int i = 0; i < 20; i++) begin
         send4(pt(4'((i*7+3) & 15)), i == 19);
         model_sym(4'((i*7+3) & 15), i == 19);
      end
      if4.s_valid = 1'b0;
      repeat (20) @(negedge clk);
      cmp_bytes("bp");
      chk("bp_s_ready_dropped", saw_stall, 1);
      chk("bp_data_stable", unstable, 0);

      // Reset mid-frame while a hi nibble is held
      send4(pt(4'd7), 1'b0);
      if4.s_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_s_ready", if4.s_ready, 0);
      chk("midrst_m_valid", if4.m_valid, 0);
      chk("midrst_m_data",  if4.m_data, 0);
      chk("midrst_m_last",  if4.m_last, 0);
      chk("midrst_m_pad",   if4.m_pad, 0);
      rst_n = 1'b1;
      @(negedge clk);
      cap.delete();
      send4(pt(4'd3), 1'b0); send4(pt(4'd12), 1'b1);
      if4.s_valid = 1'b0;
      exp_q.push_back({2'b10, 8'h3C});
      repeat (4) @(negedge clk);
      cmp_bytes("midrst");

`ifdef QAM16_DEMAP_EVM_EN
      send1(16'h0102, 1'b0); send1(16'h0000, 1'b1);
      if1.s_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("evm_sum", err_acc1, 4'd3);
      err_clr1 = 1'b1;
      @(negedge clk);
      err_clr1 = 1'b0;
      chk("evm_clr", err_acc1, 4'd0);
      send1(16'h0102, 1'b0);
      if1.s_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("evm_after_clr", err_acc1, 4'd1);
      send1(16'h7F7F, 1'b1);
      if1.s_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("evm_sat", err_acc1, 4'd15);
      send1(16'h0000, 1'b0);
      if1.s_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("evm_sat_hold", err_acc1, 4'd15);
`else
      send1(16'h0102, 1'b0); send1(16'h0000, 1'b1);
      if1.s_valid = 1'b0;
      err_clr1 = 1'b1;
      repeat (2) @(negedge clk);
      err_clr1 = 1'b0;
      chk("no_evm_acc1", err_acc1, 0);
      chk("no_evm_acc4", err_acc4, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
